// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: a word accepted on load_valid/load_ready comes out MSB- or LSB-first on x,
// first bit one cycle after the handshake; hold freezes shifting; load_ready drops while a frame or gap is in flight.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             x,
  output logic             bit_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned     CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);
  localparam logic [3:0]      GAP_LD   = 4'(GAP);
  localparam bit              NO_GAP   = (GAP == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             x_q, x_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_done_q, frame_done_d;

  logic             frame_last;
  logic             load_accept;
  logic             first_bit;
  logic [WIDTH-1:0] first_rest;
  logic             next_bit;
  logic [WIDTH-1:0] next_rest;

  // The register holds only the bits not yet presented; x_q carries the current one.
  assign first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign first_rest = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
  assign next_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign next_rest  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  assign frame_last  = (cnt_q == CNT_LAST);
  assign load_ready  = (state_q == ST_IDLE) ||
                       (NO_GAP && (state_q == ST_SHIFT) && frame_last && !hold);
  assign load_accept = load_ready && load_valid;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    x_d          = x_q;
    bit_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (load_accept) begin
      state_d     = ST_SHIFT;
      shreg_d     = first_rest;
      x_d         = first_bit;
      bit_valid_d = 1'b1;
      cnt_d       = CNT_ONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          x_d = 1'b0;
        end
        ST_SHIFT: begin
          if (!hold) begin
            if (!frame_last) begin
              x_d          = next_bit;
              shreg_d      = next_rest;
              cnt_d        = cnt_q + CNT_ONE;
              bit_valid_d  = 1'b1;
              frame_done_d = ((cnt_q + CNT_ONE) == CNT_LAST);
            end else if (NO_GAP) begin
              state_d = ST_IDLE;
              x_d     = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_LD;
              x_d     = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        ST_GAP: begin
          x_d = 1'b0;
          if (!hold) begin
            gap_d = gap_q - 4'd1;
            if (gap_q == 4'd1) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          x_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      x_q          <= 1'b0;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      x_q          <= x_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign x          = x_q;
  assign bit_valid  = bit_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: three serializer configurations (MSB/no gap, MSB/gap 2, LSB/no gap) on shared stimulus.
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       hold;

  logic lr_a, x_a, bv_a, fd_a, busy_a;
  logic lr_b, x_b, bv_b, fd_b, busy_b;
  logic lr_c, x_c, bv_c, fd_c, busy_c;

  int checks   = 0;
  int failures = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr_a), .hold(hold), .x(x_a), .bit_valid(bv_a),
    .frame_done(fd_a), .busy(busy_a)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr_b), .hold(hold), .x(x_b), .bit_valid(bv_b),
    .frame_done(fd_b), .busy(busy_b)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) dut_c (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr_c), .hold(hold), .x(x_c), .bit_valid(bv_c),
    .frame_done(fd_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  // Vectors compared below are {x, bit_valid, frame_done, load_ready, busy}.
  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    hold       = 1'b0;
    data_in    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({x_a, bv_a, fd_a, lr_a, busy_a, x_b, bv_b, fd_b, lr_b, busy_b, x_c, bv_c, fd_c, lr_c, busy_c}
        !== {3{5'b00010}}) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b",
               {x_a, bv_a, fd_a, lr_a, busy_a, x_b, bv_b, fd_b, lr_b, busy_b, x_c, bv_c, fd_c, lr_c, busy_c},
               {3{5'b00010}});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({x_a, bv_a, fd_a, lr_a, busy_a, x_b, bv_b, fd_b, lr_b, busy_b} !== {2{5'b00010}}) begin
        failures++;
        $display("FAIL idle_after_reset cycle %0d: got %b expected %b", i,
                 {x_a, bv_a, fd_a, lr_a, busy_a, x_b, bv_b, fd_b, lr_b, busy_b}, {2{5'b00010}});
      end
    end
  endtask

  task automatic test_msb_single(input logic [7:0] w);
    logic [4:0] exp;
    do_reset();
    data_in    = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    data_in    = ~w;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      exp = {w[7-i], 1'b1, (i == 7), (i == 7), 1'b1};
      checks++;
      if ({x_a, bv_a, fd_a, lr_a, busy_a} !== exp) begin
        failures++;
        $display("FAIL msb_single w=%h bit %0d: got %b expected %b", w, i,
                 {x_a, bv_a, fd_a, lr_a, busy_a}, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({x_a, bv_a, fd_a, lr_a, busy_a} !== 5'b00010) begin
      failures++;
      $display("FAIL msb_single_end w=%h: got %b expected %b", w, {x_a, bv_a, fd_a, lr_a, busy_a}, 5'b00010);
    end
  endtask

  task automatic test_lsb(input logic [7:0] w);
    logic [4:0] exp;
    do_reset();
    data_in    = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      exp = {w[i], 1'b1, (i == 7), (i == 7), 1'b1};
      checks++;
      if ({x_c, bv_c, fd_c, lr_c, busy_c} !== exp) begin
        failures++;
        $display("FAIL lsb_order w=%h bit %0d: got %b expected %b", w, i,
                 {x_c, bv_c, fd_c, lr_c, busy_c}, exp);
      end
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] w0, input logic [7:0] w1);
    logic [7:0] w;
    logic [4:0] exp;
    do_reset();
    data_in    = w0;
    load_valid = 1'b1;
    @(negedge clk);
    data_in = w1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      w   = (i < 8) ? w0 : w1;
      exp = {w[7-(i%8)], 1'b1, (i % 8 == 7), (i % 8 == 7), 1'b1};
      checks++;
      if ({x_a, bv_a, fd_a, lr_a, busy_a} !== exp) begin
        failures++;
        $display("FAIL back_to_back %h/%h cycle %0d: got %b expected %b", w0, w1, i,
                 {x_a, bv_a, fd_a, lr_a, busy_a}, exp);
      end
      if (i == 8) load_valid = 1'b0;
    end
  endtask

  task automatic test_gap(input logic [7:0] w0, input logic [7:0] w1);
    logic [7:0] w;
    logic [4:0] exp;
    int p;
    do_reset();
    data_in    = w0;
    load_valid = 1'b1;
    @(negedge clk);
    data_in = w1;
    // Each frame with load_valid held occupies 8 bits + 2 gap + 1 idle cycle.
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 11) load_valid = 1'b0;
      p = c % 11;
      w = (c < 11) ? w0 : w1;
      if (p < 8)       exp = {w[7-p], 1'b1, (p == 7), 1'b0, 1'b1};
      else if (p < 10) exp = 5'b00001;
      else             exp = 5'b00010;
      checks++;
      if ({x_b, bv_b, fd_b, lr_b, busy_b} !== exp) begin
        failures++;
        $display("FAIL gap2 %h/%h cycle %0d: got %b expected %b", w0, w1, c,
                 {x_b, bv_b, fd_b, lr_b, busy_b}, exp);
      end
    end
  endtask

  task automatic test_hold(input logic [7:0] w, input int k, input int h);
    logic [4:0] exp;
    int idx;
    logic v;
    do_reset();
    data_in    = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 0; c < 8 + h; c++) begin
      if (c > 0) @(negedge clk);
      if (c < k)          begin idx = c;     v = 1'b1; end
      else if (c < k + h) begin idx = k - 1; v = 1'b0; end
      else                begin idx = c - h; v = 1'b1; end
      exp = {w[7-idx], v, (v && idx == 7), (v && idx == 7), 1'b1};
      checks++;
      if ({x_a, bv_a, fd_a, lr_a, busy_a} !== exp) begin
        failures++;
        $display("FAIL hold w=%h k=%0d h=%0d cycle %0d: got %b expected %b", w, k, h, c,
                 {x_a, bv_a, fd_a, lr_a, busy_a}, exp);
      end
      hold = (c >= k - 1) && (c < k - 1 + h);
    end
    hold = 1'b0;
    @(negedge clk);
    checks++;
    if ({x_a, bv_a, fd_a, lr_a, busy_a} !== 5'b00010) begin
      failures++;
      $display("FAIL hold_end w=%h: got %b expected %b", w, {x_a, bv_a, fd_a, lr_a, busy_a}, 5'b00010);
    end
  endtask

  task automatic test_reset_mid(input logic [7:0] w, input logic [7:0] w2);
    logic [4:0] exp;
    do_reset();
    data_in    = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 1; c < 4; c++) @(negedge clk);
    checks++;
    if ({x_a, bv_a} !== {w[4], 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_bit4 w=%h: got %b expected %b", w, {x_a, bv_a}, {w[4], 1'b1});
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({x_a, bv_a, fd_a, lr_a, busy_a} !== 5'b00010) begin
      failures++;
      $display("FAIL reset_mid_async w=%h: got %b expected %b", w, {x_a, bv_a, fd_a, lr_a, busy_a}, 5'b00010);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({x_a, bv_a, fd_a, lr_a, busy_a} !== 5'b00010) begin
        failures++;
        $display("FAIL reset_mid_release cycle %0d: got %b expected %b", c,
                 {x_a, bv_a, fd_a, lr_a, busy_a}, 5'b00010);
      end
    end
    data_in    = w2;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      exp = {w2[7-i], 1'b1, (i == 7), (i == 7), 1'b1};
      checks++;
      if ({x_a, bv_a, fd_a, lr_a, busy_a} !== exp) begin
        failures++;
        $display("FAIL reset_mid_reload w=%h bit %0d: got %b expected %b", w2, i,
                 {x_a, bv_a, fd_a, lr_a, busy_a}, exp);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    hold       = 1'b0;
    data_in    = '0;

    test_reset();
    test_msb_single(8'b1011_0110);
    repeat (3) test_msb_single(8'($urandom));
    test_back_to_back(8'hB4, 8'h2D);
    repeat (2) test_back_to_back(8'($urandom), 8'($urandom));
    test_gap(8'hB4, 8'h2D);
    test_gap(8'($urandom), 8'($urandom));
    test_hold(8'hF0, 3, 3);
    repeat (3) test_hold(8'($urandom), int'($urandom_range(7, 1)), int'($urandom_range(4, 1)));
    test_reset_mid(8'hA5, 8'h3C);
    test_reset_mid(8'($urandom), 8'($urandom));
    test_lsb(8'b0000_1101);
    repeat (2) test_lsb(8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
